vec_checker_16: RTL and testbench
=================================

VEC_CHECKER_16 -- requirements
Module: vec_checker_16

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of vector-count, fail-count and index fields.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  arms a new check run (sampled in IDLE or DONE only).
REQ-005 SHALL have port num_vec  input  CNT_W  number of vectors in the run, latched on start.
REQ-006 SHALL have port in_valid  input  1  producer presents a sample.
REQ-007 SHALL have port in_ready  output  1  checker accepts a sample this cycle.
REQ-008 SHALL have port actual  input  16  DUT output word.
REQ-009 SHALL have port expected  input  16  golden word.
REQ-010 SHALL have port mask  input  16  per-bit compare enable; 1 = compare, 0 = don't-care.
REQ-011 SHALL have ports busy, done, pass  output  1 each  run status.
REQ-012 SHALL have ports vec_count, fail_count, first_fail_idx  output  CNT_W each  run statistics.
REQ-013 SHALL have port first_fail_diff  output  16  masked XOR of the first failing sample.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-015 IDLE/DONE + start: latch num_vec, clear vec_count, fail_count, first_fail_idx, first_fail_diff; next state RUN, or DONE if num_vec==0.
REQ-016 in_ready SHALL equal 1 exactly in RUN (Moore output, no combinational path from in_valid).
REQ-017 Accept occurs when in_valid & in_ready; no accept when in_valid=0 (producer may stall any number of cycles).
REQ-018 On accept: diff = (actual ^ expected) & mask; vec_count increments by 1.
REQ-019 On accept with diff != 0: fail_count increments, saturating at 2^CNT_W-1.
REQ-020 First failing accept of a run SHALL record first_fail_idx = vec_count before increment and first_fail_diff = diff; later failures SHALL NOT overwrite them.
REQ-021 Accept that makes vec_count equal latched num_vec SHALL move RUN to DONE; in_ready drops the next cycle.
REQ-022 All statistic outputs SHALL be registered and reflect an accept one cycle after its clock edge (latency 1).
REQ-023 pass SHALL be 1 in DONE iff fail_count == 0, else 0; pass=0 outside DONE.
REQ-024 start asserted during RUN SHALL be ignored; the run continues unchanged.
REQ-025 DONE SHALL hold all results stable until the next start.
REQ-026 mask = 0 SHALL make every sample pass regardless of actual/expected.

Reset
REQ-027 reset SHALL asynchronously force state IDLE, in_ready=0, busy=0, done=0, pass=0, all counters, indices and first_fail_diff to 0.
REQ-028 reset asserted mid-RUN SHALL discard the run; after release the checker waits in IDLE for start.

Configuration
REQ-029 Macro VEC_CHECKER_ERR_ACCUM_EN defined: extra output err_bits (16) = OR of diff over all accepts in the run, cleared on start and reset.
REQ-030 Macro VEC_CHECKER_ERR_ACCUM_EN undefined: port err_bits and its register SHALL not exist; all other behaviour identical.

Verification
REQ-031 Walking-ones inverter run: num_vec=17, a from 0x0000 adding one bit per vector, actual=~a, expected=~a, mask=0xFFFF -> DONE, pass=1, vec_count=17, fail_count=0.
REQ-032 Single fault: same run, vector 5 actual bit 5 flipped -> fail_count=1, first_fail_idx=5, first_fail_diff=0x0020, pass=0.
REQ-033 Masked fault: vector 3 actual=0xFFFF vs expected=0xFFF7, mask=0xFFF7 -> counted as pass, fail_count=0.
REQ-034 Stalls and ignored start: in_valid toggled 1/0 with start pulsed in RUN, num_vec=4 -> exactly 4 accepts, DONE after 4th, counters unaffected by start.
REQ-035 Edge/reset: num_vec=0 start -> DONE, pass=1 next cycle; reset mid-run after 2 accepts -> all outputs 0, state IDLE, in_ready=0.
REQ-036 With VEC_CHECKER_ERR_ACCUM_EN: failures diff 0x0001 and 0x8000 in one run -> err_bits=0x8001, first_fail_diff=0x0001.

Source files
------------

// File: rtl/vec_checker_16.sv
// vec_checker_16: streaming 16-bit vector checker.
// Compares each accepted sample (actual vs expected under a per-bit mask),
// counts vectors and failures, and records the first failing index/diff.
// Optional build macro VEC_CHECKER_ERR_ACCUM_EN adds err_bits, the OR of
// every masked diff seen in the current run.
module vec_checker_16 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      actual,
    input  logic [15:0]      expected,
    input  logic [15:0]      mask,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] fail_count,
    output logic [CNT_W-1:0] first_fail_idx,
`ifdef VEC_CHECKER_ERR_ACCUM_EN
    output logic [15:0]      first_fail_diff,
    output logic [15:0]      err_bits
`else
    output logic [15:0]      first_fail_diff
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] num_lat;
    logic [15:0]      diff;
    logic             accept;
    logic             mismatch;
    logic [CNT_W-1:0] vec_inc;

    // Saturating increment so the failure counter never wraps back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}})
            return v;
        else
            return v + 1'b1;
    endfunction

    // Masked per-bit mismatch and handshake qualifier for the current sample.
    assign diff     = (actual ^ expected) & mask;
    assign mismatch = (diff != 16'h0000);
    assign accept   = in_valid & in_ready;
    assign vec_inc  = vec_count + 1'b1;

    // Run controller: state, status flags and run statistics, all registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            num_lat         <= '0;
            in_ready        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            vec_count       <= '0;
            fail_count      <= '0;
            first_fail_idx  <= '0;
            first_fail_diff <= '0;
`ifdef VEC_CHECKER_ERR_ACCUM_EN
            err_bits        <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        num_lat         <= num_vec;
                        vec_count       <= '0;
                        fail_count      <= '0;
                        first_fail_idx  <= '0;
                        first_fail_diff <= '0;
`ifdef VEC_CHECKER_ERR_ACCUM_EN
                        err_bits        <= '0;
`endif
                        if (num_vec == '0) begin
                            // Empty run completes immediately with nothing failed.
                            state    <= DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            pass     <= 1'b1;
                        end else begin
                            state    <= RUN;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                            pass     <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    // start is deliberately not looked at here: a run cannot be restarted.
                    if (accept) begin
                        vec_count <= vec_inc;
                        if (mismatch) begin
                            fail_count <= sat_inc(fail_count);
                            // fail_count never returns to zero within a run, so this
                            // marks the first failure only.
                            if (fail_count == '0) begin
                                first_fail_idx  <= vec_count;
                                first_fail_diff <= diff;
                            end
                        end
`ifdef VEC_CHECKER_ERR_ACCUM_EN
                        err_bits <= err_bits | diff;
`endif
                        if (vec_inc == num_lat) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            pass     <= (fail_count == '0) && !mismatch;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    pass     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_checker_16.sv
// Testbench for vec_checker_16: directed and randomized runs compared
// against a behavioural model of the checking rules.
module tb_vec_checker_16;

    localparam int CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] num_vec;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      actual;
    logic [15:0]      expected;
    logic [15:0]      mask;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] vec_count;
    logic [CNT_W-1:0] fail_count;
    logic [CNT_W-1:0] first_fail_idx;
    logic [15:0]      first_fail_diff;
`ifdef VEC_CHECKER_ERR_ACCUM_EN
    logic [15:0]      err_bits;
`endif

    vec_checker_16 #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .num_vec        (num_vec),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .actual         (actual),
        .expected       (expected),
        .mask           (mask),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .vec_count      (vec_count),
        .fail_count     (fail_count),
        .first_fail_idx (first_fail_idx),
`ifdef VEC_CHECKER_ERR_ACCUM_EN
        .first_fail_diff(first_fail_diff),
        .err_bits       (err_bits)
`else
        .first_fail_diff(first_fail_diff)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state for the current run
    int          m_cnt;
    int          m_fail;
    int          m_ffi;
    logic [15:0] m_ffd;
    logic [15:0] m_err;

    // Vectors of the current run
    logic [15:0] qa[$];
    logic [15:0] qe[$];
    logic [15:0] qm[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, in_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_vcnt"}, vec_count, 0);
        chk({tag, "_fcnt"}, fail_count, 0);
        chk({tag, "_ffi"}, first_fail_idx, 0);
        chk({tag, "_ffd"}, first_fail_diff, 0);
`ifdef VEC_CHECKER_ERR_ACCUM_EN
        chk({tag, "_err"}, err_bits, 0);
`endif
    endtask

    // Pulse start with n vectors; model statistics restart from zero.
    task automatic begin_run(input string tag, input int n);
        m_cnt = 0; m_fail = 0; m_ffi = 0; m_ffd = '0; m_err = '0;
        @(negedge clk);
        start    = 1'b1;
        num_vec  = n[CNT_W-1:0];
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_start_vcnt"}, vec_count, 0);
        chk({tag, "_start_fcnt"}, fail_count, 0);
        chk({tag, "_start_busy"}, busy, (n != 0));
        chk({tag, "_start_ready"}, in_ready, (n != 0));
        chk({tag, "_start_done"}, done, (n == 0));
    endtask

    // Present one sample after a number of idle cycles; optionally pulse start while idle.
    task automatic send(input string tag, input logic [15:0] a, input logic [15:0] e,
                        input logic [15:0] m, input int stall, input bit poke);
        logic [15:0] d;
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b0;
            start    = poke;
            num_vec  = CNT_W'($urandom);
            actual   = 16'($urandom);
            @(negedge clk);
        end
        start    = 1'b0;
        in_valid = 1'b1;
        actual   = a;
        expected = e;
        mask     = m;
        @(negedge clk);
        in_valid = 1'b0;
        d = (a ^ e) & m;
        if (d != 0) begin
            if (m_fail == 0) begin
                m_ffi = m_cnt;
                m_ffd = d;
            end
            m_fail = (m_fail < 255) ? m_fail + 1 : 255;
        end
        m_err = m_err | d;
        m_cnt++;
        chk({tag, "_acc_vcnt"}, vec_count, m_cnt);
        chk({tag, "_acc_fcnt"}, fail_count, m_fail);
    endtask

    task automatic finish_checks(input string tag);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, in_ready, 0);
        chk({tag, "_pass"}, pass, (m_fail == 0));
        chk({tag, "_vcnt"}, vec_count, m_cnt);
        chk({tag, "_fcnt"}, fail_count, m_fail);
        chk({tag, "_ffi"}, first_fail_idx, m_ffi);
        chk({tag, "_ffd"}, first_fail_diff, m_ffd);
`ifdef VEC_CHECKER_ERR_ACCUM_EN
        chk({tag, "_err"}, err_bits, m_err);
`endif
        // Samples offered in DONE must be ignored and results must hold.
        in_valid = 1'b1;
        actual   = ~expected;
        mask     = 16'hFFFF;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_hold_vcnt"}, vec_count, m_cnt);
        chk({tag, "_hold_fcnt"}, fail_count, m_fail);
        chk({tag, "_hold_done"}, done, 1);
        chk({tag, "_hold_pass"}, pass, (m_fail == 0));
    endtask

    task automatic do_run(input string tag, input int stallmax, input bit poke);
        begin_run(tag, qa.size());
        for (int i = 0; i < qa.size(); i++)
            send(tag, qa[i], qe[i], qm[i], (stallmax > 0) ? int'($urandom_range(stallmax, 0)) : 0, poke);
        finish_checks(tag);
    endtask

    task automatic clear_q();
        qa.delete(); qe.delete(); qm.delete();
    endtask

    task automatic walk_vectors();
        logic [15:0] a;
        clear_q();
        for (int i = 0; i < 17; i++) begin
            a = (i == 0) ? 16'h0000 : 16'((32'h1 << i) - 1);
            qa.push_back(~a);
            qe.push_back(~a);
            qm.push_back(16'hFFFF);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        num_vec  = '0;
        in_valid = 1'b0;
        actual   = '0;
        expected = '0;
        mask     = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("idle");

        // Walking-ones inverter run, all clean
        walk_vectors();
        do_run("walk", 0, 1'b0);
        chk("walk_pass_const", pass, 1);
        chk("walk_vcnt_const", vec_count, 17);

        // Single fault at vector 5, bit 5
        walk_vectors();
        qa[5] = qa[5] ^ 16'h0020;
        do_run("fault", 0, 1'b0);
        chk("fault_ffi_const", first_fail_idx, 5);
        chk("fault_ffd_const", first_fail_diff, 16'h0020);
        chk("fault_fcnt_const", fail_count, 1);

        // Masked-out difference at vector 3
        walk_vectors();
        qa[3] = 16'hFFFF; qe[3] = 16'hFFF7; qm[3] = 16'hFFF7;
        do_run("masked", 1, 1'b0);
        chk("masked_fcnt_const", fail_count, 0);

        // Stalls with start pulsed during RUN
        clear_q();
        for (int i = 0; i < 4; i++) begin
            qe.push_back(16'($urandom));
            qa.push_back(qe[i] ^ ((i == 2) ? 16'h0100 : 16'h0000));
            qm.push_back(16'hFFFF);
        end
        do_run("stall", 3, 1'b1);
        chk("stall_vcnt_const", vec_count, 4);

        // Empty run
        clear_q();
        do_run("empty", 0, 1'b0);

        // mask = 0 makes everything pass
        clear_q();
        for (int i = 0; i < 6; i++) begin
            qa.push_back(16'($urandom));
            qe.push_back(~qa[i]);
            qm.push_back(16'h0000);
        end
        do_run("mask0", 1, 1'b0);

        // Two failures: 0x0001 then 0x8000
        clear_q();
        qe.push_back(16'h1234); qa.push_back(16'h1235); qm.push_back(16'hFFFF);
        qe.push_back(16'h5555); qa.push_back(16'h5555); qm.push_back(16'hFFFF);
        qe.push_back(16'h0F0F); qa.push_back(16'h8F0F); qm.push_back(16'hFFFF);
        qe.push_back(16'hAAAA); qa.push_back(16'hAAAA); qm.push_back(16'hFFFF);
        do_run("accum", 2, 1'b0);
        chk("accum_ffd_const", first_fail_diff, 16'h0001);
`ifdef VEC_CHECKER_ERR_ACCUM_EN
        chk("accum_err_const", err_bits, 16'h8001);
`endif

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            int n;
            clear_q();
            n = $urandom_range(20, 1);
            for (int i = 0; i < n; i++) begin
                logic [15:0] e;
                e = 16'($urandom);
                qe.push_back(e);
                qa.push_back(($urandom_range(3, 0) == 0) ? (e ^ (16'h1 << $urandom_range(15, 0))) : e);
                qm.push_back(16'($urandom));
            end
            do_run("rand", 3, 1'($urandom_range(1, 0)));
        end

        // Reset in the middle of a run after two accepts
        begin_run("midrst", 6);
        send("midrst", 16'h00FF, 16'h00FE, 16'hFFFF, 0, 1'b0);
        send("midrst", 16'h1111, 16'h1111, 16'hFFFF, 0, 1'b0);
        #2 reset = 1'b1;
        #1 chk_all_zero("midrst_async");
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk_all_zero("midrst_after");

        // New run works after the discarded one
        walk_vectors();
        do_run("post", 1, 1'b0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
